ss_issue_ctrl: RTL and testbench

Dual-issue scheduler for the two-pipe superscalar MIPS core, sitting between decode and the D→E pipeline registers of both pipes. Each cycle it decides whether the decoded instruction pair issues together, splits across two cycles, or stalls. It also drives the fetch/decode stall lines and keeps saturating issue-statistics counters. Forwarding is handled downstream. This block removes only the hazards that forwarding cannot cover: intra-pair RAW, load-use, load-to-branch, and memory-port conflicts.

---
 rtl/ss_issue_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ss_issue_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ss_issue_ctrl.sv
// ss_issue_ctrl: dual-issue scheduler between decode and both D->E registers.
// Ports: decode pair (ValidD*/Rs/Rt/WriteRegD1/RegWriteD1/MemOp/Branch),
//   E/M load state per pipe, FlushD, CntClr -> IssueE1/2, SlotSel,
//   StallF/StallD, saturating CntDual/CntSplit/CntStall.
module ss_issue_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ValidD1,
  input  logic             ValidD2,
  input  logic [4:0]       RsD1,
  input  logic [4:0]       RtD1,
  input  logic [4:0]       RsD2,
  input  logic [4:0]       RtD2,
  input  logic [4:0]       WriteRegD1,
  input  logic             RegWriteD1,
  input  logic             MemOpD1,
  input  logic             MemOpD2,
  input  logic             BranchD1,
  input  logic             BranchD2,
  input  logic             MemReadE1,
  input  logic             MemReadE2,
  input  logic [4:0]       WriteRegE1,
  input  logic [4:0]       WriteRegE2,
  input  logic             MemReadM1,
  input  logic             MemReadM2,
  input  logic [4:0]       WriteRegM1,
  input  logic [4:0]       WriteRegM2,
  input  logic             FlushD,
  input  logic             CntClr,
  output logic             IssueE1,
  output logic             IssueE2,
  output logic             SlotSel,
  output logic             StallF,
  output logic             StallD,
  output logic [CNT_W-1:0] CntDual,
  output logic [CNT_W-1:0] CntSplit,
  output logic [CNT_W-1:0] CntStall
);

  typedef enum logic {PAIR = 1'b0, SPLIT2 = 1'b1} state_e;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e r_state;
  state_e w_nxt;

  logic [CNT_W-1:0] r_dual;
  logic [CNT_W-1:0] r_split;
  logic [CNT_W-1:0] r_stall;

  logic w_lu1, w_lu2, w_lb1, w_lb2;
  logic w_hz1, w_hz2, w_raw, w_conf;
  logic w_iss1, w_iss2, w_sel, w_stl;
  logic w_inc_d, w_inc_sp, w_inc_st;

  // register 0 is never a real dependence
  function automatic logic hit(input logic [4:0] s,
                               input logic [4:0] d,
                               input logic       en);
    return en && (s != 5'd0) && (s == d);
  endfunction

  assign w_lu1 = hit(RsD1, WriteRegE1, MemReadE1)
               | hit(RtD1, WriteRegE1, MemReadE1)
               | hit(RsD1, WriteRegE2, MemReadE2)
               | hit(RtD1, WriteRegE2, MemReadE2);
  assign w_lu2 = hit(RsD2, WriteRegE1, MemReadE1)
               | hit(RtD2, WriteRegE1, MemReadE1)
               | hit(RsD2, WriteRegE2, MemReadE2)
               | hit(RtD2, WriteRegE2, MemReadE2);
  assign w_lb1 = BranchD1 &
                 (hit(RsD1, WriteRegM1, MemReadM1)
                | hit(RtD1, WriteRegM1, MemReadM1)
                | hit(RsD1, WriteRegM2, MemReadM2)
                | hit(RtD1, WriteRegM2, MemReadM2));
  assign w_lb2 = BranchD2 &
                 (hit(RsD2, WriteRegM1, MemReadM1)
                | hit(RtD2, WriteRegM1, MemReadM1)
                | hit(RsD2, WriteRegM2, MemReadM2)
                | hit(RtD2, WriteRegM2, MemReadM2));

  assign w_hz1  = w_lu1 | w_lb1;
  assign w_hz2  = w_lu2 | w_lb2;
  assign w_raw  = RegWriteD1 && (WriteRegD1 != 5'd0) &&
                  ((WriteRegD1 == RsD2) || (WriteRegD1 == RtD2));
  assign w_conf = (MemOpD1 & MemOpD2) | BranchD1 | BranchD2;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= PAIR;
    else         r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    if (FlushD) begin
      w_nxt = PAIR;
    end else begin
      unique case (r_state)
        PAIR: begin
          if (ValidD1 && !w_hz1 && ValidD2 &&
              (w_raw || w_conf || w_hz2))
            w_nxt = SPLIT2;
        end
        SPLIT2: begin
          if (!w_hz2) w_nxt = PAIR;
        end
        default: w_nxt = PAIR;
      endcase
    end
  end

  always_comb begin
    w_iss1   = 1'b0;
    w_iss2   = 1'b0;
    w_sel    = 1'b0;
    w_stl    = 1'b0;
    w_inc_d  = 1'b0;
    w_inc_sp = 1'b0;
    w_inc_st = 1'b0;
    if (!FlushD) begin
      unique case (r_state)
        PAIR: begin
          if (!ValidD1) begin
            w_iss1 = 1'b0;
          end else if (w_hz1) begin
            w_stl    = 1'b1;
            w_inc_st = 1'b1;
          end else if (!ValidD2) begin
            w_iss1 = 1'b1;
          end else if (w_raw || w_conf || w_hz2) begin
            w_iss1   = 1'b1;
            w_stl    = 1'b1;
            w_inc_sp = 1'b1;
          end else begin
            w_iss1  = 1'b1;
            w_iss2  = 1'b1;
            w_inc_d = 1'b1;
          end
        end
        SPLIT2: begin
          if (w_hz2) begin
            w_stl    = 1'b1;
            w_inc_st = 1'b1;
          end else begin
            w_iss1 = 1'b1;
            w_sel  = 1'b1;
          end
        end
        default: w_iss1 = 1'b0;
      endcase
    end
  end

  // outputs held low for the whole reset window, not just after an edge
  assign IssueE1 = resetn & w_iss1;
  assign IssueE2 = resetn & w_iss2;
  assign SlotSel = resetn & w_sel;
  assign StallF  = resetn & w_stl;
  assign StallD  = resetn & w_stl;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_dual  <= '0;
      r_split <= '0;
      r_stall <= '0;
    end else if (CntClr) begin
      r_dual  <= '0;
      r_split <= '0;
      r_stall <= '0;
    end else begin
      if (w_inc_d && (r_dual != '1))
        r_dual <= r_dual + ONE;
      if (w_inc_sp && (r_split != '1))
        r_split <= r_split + ONE;
      if (w_inc_st && (r_stall != '1))
        r_stall <= r_stall + ONE;
    end
  end

  assign CntDual  = r_dual;
  assign CntSplit = r_split;
  assign CntStall = r_stall;

endmodule

// File: tb/tb_ss_issue_ctrl.sv
// tb_ss_issue_ctrl: table-driven vectors with an expected-output queue,
// plus hand sequences for reset mid-split and counter saturation/clear.
module tb_ss_issue_ctrl;

  localparam int W = 16;

  typedef struct packed {
    logic       vd1, vd2;
    logic [4:0] rs1, rt1, rs2, rt2, wr1;
    logic       rw1, mo1, mo2, br1, br2, mre1, mre2;
    logic [4:0] wre1, wre2;
    logic       mrm1, mrm2;
    logic [4:0] wrm1, wrm2;
    logic       flush, clr;
  } in_t;

  // {IssueE1, IssueE2, SlotSel, StallF, StallD}
  typedef logic [4:0] out_t;

  typedef struct packed {
    in_t  in;
    out_t exp;
    logic dd, dsp, dst;
  } vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  in_t  d;
  logic IssueE1, IssueE2, SlotSel, StallF, StallD;
  logic [W-1:0] CntDual, CntSplit, CntStall;

  int checks = 0;
  int failures = 0;
  int m_dual = 0, m_split = 0, m_stall = 0;
  out_t sb[$];
  vec_t tv[$];

  always #5 clk = ~clk;

  ss_issue_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .resetn(resetn),
    .ValidD1(d.vd1), .ValidD2(d.vd2),
    .RsD1(d.rs1), .RtD1(d.rt1), .RsD2(d.rs2), .RtD2(d.rt2),
    .WriteRegD1(d.wr1), .RegWriteD1(d.rw1),
    .MemOpD1(d.mo1), .MemOpD2(d.mo2),
    .BranchD1(d.br1), .BranchD2(d.br2),
    .MemReadE1(d.mre1), .MemReadE2(d.mre2),
    .WriteRegE1(d.wre1), .WriteRegE2(d.wre2),
    .MemReadM1(d.mrm1), .MemReadM2(d.mrm2),
    .WriteRegM1(d.wrm1), .WriteRegM2(d.wrm2),
    .FlushD(d.flush), .CntClr(d.clr),
    .IssueE1(IssueE1), .IssueE2(IssueE2), .SlotSel(SlotSel),
    .StallF(StallF), .StallD(StallD),
    .CntDual(CntDual), .CntSplit(CntSplit), .CntStall(CntStall)
  );

  function automatic out_t outs();
    return {IssueE1, IssueE2, SlotSel, StallF, StallD};
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, " CntDual"},  32'(CntDual),  32'(m_dual));
    chk({nm, " CntSplit"}, 32'(CntSplit), 32'(m_split));
    chk({nm, " CntStall"}, 32'(CntStall), 32'(m_stall));
  endtask

  function automatic int sat(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    out_t e;
    @(posedge clk); #1;
    chk_cnt(nm);
    d = v.in;
    sb.push_back(v.exp);
    @(negedge clk);
    e = sb.pop_front();
    chk({nm, " outs"}, 32'(outs()), 32'(e));
    if (v.in.clr) begin
      m_dual = 0; m_split = 0; m_stall = 0;
    end else begin
      if (v.dd)  m_dual  = sat(m_dual);
      if (v.dsp) m_split = sat(m_split);
      if (v.dst) m_stall = sat(m_stall);
    end
  endtask

  task automatic add(input in_t i, input out_t e,
                     input logic dd, input logic dsp, input logic dst);
    vec_t v;
    v.in = i; v.exp = e; v.dd = dd; v.dsp = dsp; v.dst = dst;
    tv.push_back(v);
  endtask

  in_t p;
  in_t q;

  initial begin
    // 0 idle
    p = '0;
    add(p, 5'b00000, 0, 0, 0);
    // 1 independent pair
    p = '0; p.vd1 = 1; p.vd2 = 1; p.rs2 = 3; p.wr1 = 5; p.rw1 = 1;
    add(p, 5'b11000, 1, 0, 0);
    // 2,3 RAW via RsD2
    p.rs2 = 5;
    add(p, 5'b10011, 0, 1, 0);
    add(p, 5'b10100, 0, 0, 0);
    // 4,5 load-use on slot 1 then resolved
    p = '0; p.vd1 = 1; p.vd2 = 1; p.rs1 = 8; p.rs2 = 3;
    p.wr1 = 5; p.rw1 = 1; p.mre2 = 1; p.wre2 = 8;
    add(p, 5'b00011, 0, 0, 1);
    p.mre2 = 0;
    add(p, 5'b11000, 1, 0, 0);
    // 6 zero register never matches
    p.rs1 = 0; p.rt1 = 0; p.mre2 = 1; p.wre2 = 0;
    add(p, 5'b11000, 1, 0, 0);
    // 7,8,9 two loads split, slot 2 load-use in SPLIT2
    p = '0; p.vd1 = 1; p.vd2 = 1; p.mo1 = 1; p.mo2 = 1;
    p.rs1 = 1; p.rs2 = 4;
    add(p, 5'b10011, 0, 1, 0);
    p.mre1 = 1; p.wre1 = 4;
    add(p, 5'b00011, 0, 0, 1);
    p.mre1 = 0;
    add(p, 5'b10100, 0, 0, 0);
    // 10 lone slot 1
    p = '0; p.vd1 = 1; p.rs1 = 2;
    add(p, 5'b10000, 0, 0, 0);
    // 11,12 branch in slot 2 splits, flush drops slot 2
    p = '0; p.vd1 = 1; p.vd2 = 1; p.br2 = 1; p.rs2 = 7;
    add(p, 5'b10011, 0, 1, 0);
    p.flush = 1;
    add(p, 5'b00000, 0, 0, 0);
    // 13,14 back in PAIR: same pair splits from the start
    p.flush = 0;
    add(p, 5'b10011, 0, 1, 0);
    add(p, 5'b10100, 0, 0, 0);
    // 15,16 load-to-branch on slot 1, then flushed
    p = '0; p.vd1 = 1; p.br1 = 1; p.rs1 = 6; p.mrm1 = 1; p.wrm1 = 6;
    add(p, 5'b00011, 0, 0, 1);
    p.flush = 1;
    add(p, 5'b00000, 0, 0, 0);
    // 17 no RAW without RegWriteD1
    p = '0; p.vd1 = 1; p.vd2 = 1; p.wr1 = 5; p.rs2 = 5;
    add(p, 5'b11000, 1, 0, 0);
    // 18,19 clear beats increment, then counts resume
    p.clr = 1;
    add(p, 5'b11000, 1, 0, 0);
    p.clr = 0;
    add(p, 5'b11000, 1, 0, 0);
    // 20 M-stage load only hurts a branch
    p = '0; p.vd1 = 1; p.rs1 = 6; p.mrm1 = 1; p.wrm1 = 6;
    add(p, 5'b10000, 0, 0, 0);
    // 21,22 RAW via RtD2
    p = '0; p.vd1 = 1; p.vd2 = 1; p.wr1 = 9; p.rw1 = 1; p.rt2 = 9;
    add(p, 5'b10011, 0, 1, 0);
    add(p, 5'b10100, 0, 0, 0);

    // reset state with a pair that would otherwise dual-issue
    d = '0; d.vd1 = 1; d.vd2 = 1;
    #3;
    chk("reset outs", 32'(outs()), 32'd0);
    chk_cnt("reset");
    #9 resetn = 1'b1;
    d = '0;

    foreach (tv[i]) apply(tv[i], $sformatf("vec%0d", i));
    @(posedge clk); #1;
    d = '0;
    chk_cnt("post-table");

    // async reset in the middle of a split
    q = '0; q.vd1 = 1; q.vd2 = 1; q.wr1 = 5; q.rw1 = 1; q.rs2 = 5;
    d = q;
    @(negedge clk);
    chk("rst-split first half", 32'(outs()), 32'(5'b10011));
    @(posedge clk); #1;
    chk("rst-split in SPLIT2", 32'(outs()), 32'(5'b10100));
    #1 resetn = 1'b0;
    #1;
    chk("rst-split outs low", 32'(outs()), 32'd0);
    m_dual = 0; m_split = 0; m_stall = 0;
    chk_cnt("rst-split");
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("rst-split back in PAIR", 32'(outs()), 32'(5'b10011));

    // saturation of the dual counter
    p = '0; p.vd1 = 1; p.vd2 = 1; p.rs2 = 3; p.wr1 = 5; p.rw1 = 1;
    @(posedge clk); #1;
    d = p; d.clr = 1;
    @(posedge clk); #1;
    d.clr = 0;
    chk("sat start", 32'(CntDual), 32'd0);
    repeat (65535) @(posedge clk);
    #1;
    chk("sat 65535", 32'(CntDual), 32'hFFFF);
    @(posedge clk); #1;
    chk("sat hold", 32'(CntDual), 32'hFFFF);
    chk("sat split", 32'(CntSplit), 32'd0);
    chk("sat stall", 32'(CntStall), 32'd0);
    d.clr = 1;
    @(posedge clk); #1;
    chk("clr over inc", 32'(CntDual), 32'd0);
    d = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
